// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: 1-to-4 time-division demultiplexer.
// Aligns to frame_sync, collects slots 0..2 in shadow registers and publishes
// all four channels together on the slot-3 beat. Repeated missing syncs drop
// lock; a sync seen mid-frame restarts the frame and flags frame_err.
module tdm_demux_4ch #(
  parameter int WIDTH    = 4,
  parameter int MISS_MAX = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             frame_valid,
  output logic             frame_err,
  output logic             locked,
  output logic [1:0]       slot
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state;
  logic [3:0]       miss;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic             miss_limit;

  // True when one more missing sync would reach the loss-of-lock threshold.
  assign miss_limit = ({1'b0, miss} + 5'd1) >= 5'(MISS_MAX);

  // Alignment FSM, slot routing and atomic channel publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      miss        <= '0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      ch0         <= '0;
      ch1         <= '0;
      ch2         <= '0;
      ch3         <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      locked      <= 1'b0;
      slot        <= 2'd0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              sh0    <= din;
              slot   <= 2'd1;
              miss   <= '0;
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              // A sync anywhere but slot 0 throws away the partial frame.
              frame_err <= (slot != 2'd0);
              sh0       <= din;
              slot      <= 2'd1;
              miss      <= '0;
            end else begin
              case (slot)
                2'd0: begin
                  if (miss_limit) begin
                    state  <= HUNT;
                    locked <= 1'b0;
                    slot   <= 2'd0;
                    miss   <= '0;
                  end else begin
                    sh0  <= din;
                    miss <= miss + 4'd1;
                    slot <= 2'd1;
                  end
                end
                2'd1: begin
                  sh1  <= din;
                  slot <= 2'd2;
                end
                2'd2: begin
                  sh2  <= din;
                  slot <= 2'd3;
                end
                default: begin
                  ch0         <= sh0;
                  ch1         <= sh1;
                  ch2         <= sh2;
                  ch3         <= din;
                  frame_valid <= 1'b1;
                  slot        <= 2'd0;
                end
              endcase
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch (WIDTH=4, MISS_MAX=2).
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [3:0] ch0, ch1, ch2, ch3;
  logic       frame_valid, frame_err, locked;
  logic [1:0] slot;

  int vecs = 0;
  int errs = 0;

  tdm_demux_4ch #(.WIDTH(4), .MISS_MAX(2)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .frame_valid(frame_valid), .frame_err(frame_err), .locked(locked),
    .slot(slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs; returns 1ns after the sampling edge.
  task automatic step(input logic v, input logic s, input logic [3:0] d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic chk_ch(input string tag, input logic [15:0] exp);
    chk(tag, {ch0, ch1, ch2, ch3}, exp);
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_ch("rst_ch", 16'h0000);
    chk("rst_fv", frame_valid, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_lock", locked, 0);
    chk("rst_slot", slot, 0);
    rst_n = 1'b1;

    // HUNT ignores unsynced beats.
    step(1, 0, 4'h7);
    step(1, 0, 4'h7);
    chk("hunt_lock", locked, 0);
    chk("hunt_slot", slot, 0);

    // Aligned frame A B C D.
    step(1, 1, 4'hA);
    chk("al_lock", locked, 1);
    chk("al_slot1", slot, 1);
    step(1, 0, 4'hB);
    step(1, 0, 4'hC);
    chk("al_fv_early", frame_valid, 0);
    step(1, 0, 4'hD);
    chk("al_fv", frame_valid, 1);
    chk("al_fe", frame_err, 0);
    chk_ch("al_ch", 16'hABCD);
    step(0, 0, 4'h0);
    chk("al_fv_pulse", frame_valid, 0);
    chk_ch("al_hold", 16'hABCD);

    // Gapped frame 1 2 3 4 with 3 idle cycles between beats.
    step(1, 1, 4'h1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 4'hF);
      chk("gap_slot", slot, 1);
      chk("gap_fv", frame_valid, 0);
    end
    step(1, 0, 4'h2);
    repeat (3) step(0, 0, 4'hE);
    step(1, 0, 4'h3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'hE);
      chk("gap_slot3", slot, 3);
      chk("gap_fv3", frame_valid, 0);
    end
    step(1, 0, 4'h4);
    chk("gap_fv_end", frame_valid, 1);
    chk_ch("gap_ch", 16'h1234);

    // Misaligned sync at slot 2.
    step(1, 1, 4'h1);
    step(1, 0, 4'h2);
    step(1, 1, 4'h9);
    chk("mis_fe", frame_err, 1);
    chk("mis_fv", frame_valid, 0);
    chk("mis_slot", slot, 1);
    chk("mis_lock", locked, 1);
    step(1, 0, 4'h8);
    chk("mis_fe_pulse", frame_err, 0);
    step(1, 0, 4'h7);
    step(1, 0, 4'h6);
    chk("mis_fv_end", frame_valid, 1);
    chk_ch("mis_ch", 16'h9876);

    // Reset mid-frame, asserted between clock edges.
    step(1, 1, 4'h3);
    step(1, 0, 4'h1);
    step(1, 0, 4'h2);
    #2 rst_n = 1'b0;
    #1;
    chk_ch("mrst_ch", 16'h0000);
    chk("mrst_lock", locked, 0);
    chk("mrst_slot", slot, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 0, 4'h5);
    chk("mrst_hunt_lock", locked, 0);
    chk("mrst_hunt_slot", slot, 0);
    chk("mrst_hunt_fv", frame_valid, 0);

    // Sync loss with MISS_MAX=2.
    step(1, 1, 4'hE);
    step(1, 0, 4'hF);
    step(1, 0, 4'h1);
    step(1, 0, 4'h2);
    chk("sl_fv0", frame_valid, 1);
    chk_ch("sl_ch0", 16'hEF12);
    step(1, 0, 4'h3);
    chk("sl_lock_miss1", locked, 1);
    step(1, 0, 4'h4);
    step(1, 0, 4'h5);
    step(1, 0, 4'h6);
    chk("sl_fv1", frame_valid, 1);
    chk_ch("sl_ch1", 16'h3456);
    step(1, 0, 4'h7);
    chk("sl_lock_lost", locked, 0);
    chk("sl_slot", slot, 0);
    chk("sl_fe", frame_err, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'h8 + 4'(i));
      chk("sl_no_fv", frame_valid, 0);
      chk("sl_hunt", locked, 0);
    end
    chk_ch("sl_ch_hold", 16'h3456);

    // Streaming: 12 back-to-back beats, sync every 4th.
    for (int i = 0; i < 12; i++) begin
      step(1, (i % 4) == 0, 4'(i + 1));
      chk("st_fv", frame_valid, ((i % 4) == 3));
      if ((i % 4) == 3)
        chk_ch("st_ch", {4'(i - 2), 4'(i - 1), 4'(i), 4'(i + 1)});
    end
    step(0, 0, 4'h0);
    chk("st_fv_after", frame_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
